branch_ctrl: RTL
================

Name: branch_ctrl

Overview:
- Sequences resolution of branch/jump instructions from the EX stage.
- Captures operands with a valid/ready handshake and evaluates the condition on an internal compare datapath instance (ops BEQ/BNE/BLT/BGE/BLTU/BGEU).
- Computes target and link address; drives fetch redirect, pipeline flush and perf counters.
- Baseline policy is predict-not-taken; optional BHT prediction.

Parameters:
- FLUSH_CYCLES, 2, cycles flush is held after an accepted redirect (legal range 1-15).
- BHT_IDX_W, 6, log2 BHT entries; used only with BRANCH_PRED_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- br_valid  in  1  branch request.
- br_ready  out  1  controller can accept a request.
- br_op  in  3  funct3 branch condition.
- br_is_jal  in  1  JAL: unconditional, target pc+imm.
- br_is_jalr  in  1  JALR: unconditional, target (rs1+imm)&~1.
- br_pred_taken  in  1  fetch-side prediction for this instruction.
- br_pc  in  32  instruction PC.
- br_imm  in  32  sign-extended offset.
- rs1_val, rs2_val  in  32 each  source operands.
- res_valid  out  1  one-cycle result strobe.
- res_taken  out  1  resolved direction.
- res_link  out  32  pc+4, for rd write.
- redirect_valid  out  1  fetch redirect request.
- redirect_ready  in  1  fetch accepts redirect.
- redirect_pc  out  32  corrected fetch PC.
- flush  out  1  kill IF/ID contents.
- exc_misalign  out  1  one-cycle pulse, taken target not 4-byte aligned.
- exc_illegal  out  1  one-cycle pulse, br_op 010/011 on a conditional branch.
- fetch_pc  in  32  BHT lookup PC.
- fetch_pred_taken  out  1  BHT lookup result.
- br_count, mispred_count  out  32 each  perf counters.

Behaviour:
- Reset (async, any state, mid-operation included):
  - State goes to IDLE. All strobes, redirect_valid, flush, res_* and redirect_pc go to 0; both counters go to 0.
  - br_ready is 1 after reset.
  - A request presented during reset is dropped.
- States: IDLE, EVAL, REDIRECT, FLUSH.
- IDLE:
  - br_ready=1.
  - On br_valid&br_ready, register all br_* and rs*_val, then go to EVAL.
- EVAL (exactly 1 cycle, br_ready=0):
  - taken = jal | jalr | cmp_out; compare uses the registered rs1/rs2/op.
  - Target = pc+imm (branch/JAL) or (rs1+imm)&~1 (JALR). All adds are 32-bit modulo; wrap is not an error.
  - Drive res_valid=1, res_taken and res_link=pc+4. br_count is incremented.
  - Illegal op: taken=0, exc_illegal=1, no redirect, next state IDLE.
  - taken & target[1]: exc_misalign=1, no redirect, no mispredict count, next state IDLE.
  - mispredict = taken != pred, where pred=0 without BRANCH_PRED_EN.
    - If mispredict: redirect_pc = taken ? target : pc+4; increment mispred_count; next state REDIRECT.
    - Otherwise: next state IDLE.
- REDIRECT:
  - redirect_valid=1; redirect_pc is held stable until redirect_ready.
  - On redirect_ready, load flush counter = FLUSH_CYCLES and go to FLUSH.
- FLUSH:
  - flush=1 for exactly FLUSH_CYCLES cycles, then IDLE.
- Latency:
  - Accept in cycle T; result in T+1.
  - Earliest redirect_valid in T+2; with redirect_ready=1, flush in T+3..T+2+FLUSH_CYCLES.
  - Not-taken correct prediction gives back-to-back throughput of one branch per 2 cycles.
- Priority: illegal > misalign > mispredict.
- Counters saturate never; they wrap at 2^32.

Optional Feature:
- BRANCH_PRED_EN defined:
  - BHT of 2^BHT_IDX_W 2-bit saturating counters, reset to 01 (weakly not-taken).
  - Indexed by pc[BHT_IDX_W+1:2].
  - fetch_pred_taken = counter[fetch_pc idx][1], combinational.
  - In EVAL, a legal conditional branch increments (taken) or decrements the entry, saturating at 11/00. JAL/JALR do not update.
  - br_pred_taken is used for mispredict.
- BRANCH_PRED_EN undefined:
  - No BHT storage; fetch_pred_taken=0.
  - br_pred_taken is ignored (pred=0).

Test Plan:
- BEQ rs1=5 rs2=5 pc=0x100 imm=0x20 -> T+1 res_taken=1, res_link=0x104; redirect_pc=0x120; flush high 2 cycles; mispred_count=1.
- BLT rs1=0xFFFFFFFF rs2=1 vs BLTU same operands -> taken=1 vs taken=0; BLTU gives no redirect, back in IDLE at T+2.
- JALR rs1=0x203 imm=0x0 -> target 0x202, exc_misalign pulse, no redirect. JALR rs1=0x201 -> redirect_pc=0x200.
- br_op=3'b010 -> exc_illegal=1, res_taken=0, br_count increments.
- Redirect with redirect_ready held 0 for 3 cycles:
  - redirect_pc stable, br_ready=0 throughout.
  - rst asserted mid-FLUSH -> flush, redirect_valid and counters 0 immediately.
- BRANCH_PRED_EN: same BNE (pc=0x40) taken 3 times with br_pred_taken = fetch_pred_taken:
  - 1st mispredicts; counter 01->10->11.
  - fetch_pred_taken(0x40)=1 after the first update; mispred_count=1.

Source files
------------

// File: rtl/branch_ctrl.sv
// Branch/jump resolution controller: operand capture, condition compare, target/link
// generation, fetch redirect, pipeline flush and perf counters. Optional BHT via BRANCH_PRED_EN.

module branch_cmp (
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        taken
);

    // Condition evaluation for the conditional branch funct3 encodings
    always_comb begin
        taken = 1'b0;
        case (op)
            3'b000:  taken = (a == b);
            3'b001:  taken = (a != b);
            3'b100:  taken = ($signed(a) < $signed(b));
            3'b101:  taken = ($signed(a) >= $signed(b));
            3'b110:  taken = (a < b);
            3'b111:  taken = (a >= b);
            default: taken = 1'b0;
        endcase
    end

endmodule

module branch_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int BHT_IDX_W    = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        br_valid,
    output logic        br_ready,
    input  logic [2:0]  br_op,
    input  logic        br_is_jal,
    input  logic        br_is_jalr,
    input  logic        br_pred_taken,
    input  logic [31:0] br_pc,
    input  logic [31:0] br_imm,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    output logic        res_valid,
    output logic        res_taken,
    output logic [31:0] res_link,
    output logic        redirect_valid,
    input  logic        redirect_ready,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic        exc_misalign,
    output logic        exc_illegal,
    input  logic [31:0] fetch_pc,
    output logic        fetch_pred_taken,
    output logic [31:0] br_count,
    output logic [31:0] mispred_count
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EVAL     = 2'd1,
        ST_REDIRECT = 2'd2,
        ST_FLUSH    = 2'd3
    } state_t;

    state_t      state_r, state_s;
    logic [3:0]  flush_cnt_r;
    logic [2:0]  op_r;
    logic        jal_r, jalr_r, pred_r;
    logic [31:0] pc_r, imm_r, rs1_r, rs2_r;
    logic [31:0] redirect_pc_r, br_count_r, mispred_count_r;

    logic        cmp_out_s, illegal_s, taken_s, misalign_s, mispred_s, pred_s;
    logic [31:0] target_s, link_s;
    logic        unused_s;

    branch_cmp u_cmp (
        .op    (op_r),
        .a     (rs1_r),
        .b     (rs2_r),
        .taken (cmp_out_s)
    );

    // Resolution of the captured instruction: direction, target, exceptions
    always_comb begin
        illegal_s = 1'b0;
        taken_s   = 1'b0;
        target_s  = 32'd0;
        link_s    = pc_r + 32'd4;
        if (!jal_r && !jalr_r && (op_r == 3'b010 || op_r == 3'b011)) begin
            illegal_s = 1'b1;
        end else begin
            illegal_s = 1'b0;
        end
        if (jal_r || jalr_r) begin
            taken_s = 1'b1;
        end else if (illegal_s) begin
            taken_s = 1'b0;
        end else begin
            taken_s = cmp_out_s;
        end
        if (jalr_r) begin
            target_s = (rs1_r + imm_r) & ~32'd1;
        end else begin
            target_s = pc_r + imm_r;
        end
        misalign_s = taken_s & target_s[1];
        mispred_s  = !illegal_s && !misalign_s && (taken_s != pred_s);
    end

    // Next-state and output decode
    always_comb begin
        state_s        = state_r;
        br_ready       = 1'b0;
        res_valid      = 1'b0;
        res_taken      = 1'b0;
        res_link       = 32'd0;
        redirect_valid = 1'b0;
        flush          = 1'b0;
        exc_illegal    = 1'b0;
        exc_misalign   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                br_ready = 1'b1;
                if (br_valid) begin
                    state_s = ST_EVAL;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_EVAL: begin
                res_valid    = 1'b1;
                res_taken    = taken_s;
                res_link     = link_s;
                exc_illegal  = illegal_s;
                exc_misalign = misalign_s;
                if (mispred_s) begin
                    state_s = ST_REDIRECT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REDIRECT: begin
                redirect_valid = 1'b1;
                if (redirect_ready) begin
                    state_s = ST_FLUSH;
                end else begin
                    state_s = ST_REDIRECT;
                end
            end
            ST_FLUSH: begin
                flush = 1'b1;
                if (flush_cnt_r <= 4'd1) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_FLUSH;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand capture, redirect target, flush timer and perf counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r            <= 3'd0;
            jal_r           <= 1'b0;
            jalr_r          <= 1'b0;
            pred_r          <= 1'b0;
            pc_r            <= 32'd0;
            imm_r           <= 32'd0;
            rs1_r           <= 32'd0;
            rs2_r           <= 32'd0;
            redirect_pc_r   <= 32'd0;
            flush_cnt_r     <= 4'd0;
            br_count_r      <= 32'd0;
            mispred_count_r <= 32'd0;
        end else begin
            if (state_r == ST_IDLE && br_valid) begin
                op_r   <= br_op;
                jal_r  <= br_is_jal;
                jalr_r <= br_is_jalr;
                pred_r <= br_pred_taken;
                pc_r   <= br_pc;
                imm_r  <= br_imm;
                rs1_r  <= rs1_val;
                rs2_r  <= rs2_val;
            end
            if (state_r == ST_EVAL) begin
                br_count_r <= br_count_r + 32'd1;
                if (mispred_s) begin
                    mispred_count_r <= mispred_count_r + 32'd1;
                    redirect_pc_r   <= taken_s ? target_s : link_s;
                end
            end
            if (state_r == ST_REDIRECT && redirect_ready) begin
                flush_cnt_r <= 4'(FLUSH_CYCLES);
            end else if (state_r == ST_FLUSH) begin
                flush_cnt_r <= flush_cnt_r - 4'd1;
            end
        end
    end

    assign redirect_pc   = redirect_pc_r;
    assign br_count      = br_count_r;
    assign mispred_count = mispred_count_r;

`ifdef BRANCH_PRED_EN
    logic [1:0] bht_r [0:(1<<BHT_IDX_W)-1];
    logic [BHT_IDX_W-1:0] upd_idx_s;

    assign upd_idx_s        = pc_r[BHT_IDX_W+1:2];
    assign fetch_pred_taken = bht_r[fetch_pc[BHT_IDX_W+1:2]][1];
    assign pred_s           = pred_r;
    assign unused_s         = ^{fetch_pc, pc_r};

    // Two-bit saturating history, trained only by legal conditional branches
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < (1 << BHT_IDX_W); i++) begin
                bht_r[i] <= 2'b01;
            end
        end else if (state_r == ST_EVAL && !jal_r && !jalr_r && !illegal_s) begin
            if (cmp_out_s && bht_r[upd_idx_s] != 2'b11) begin
                bht_r[upd_idx_s] <= bht_r[upd_idx_s] + 2'b01;
            end else if (!cmp_out_s && bht_r[upd_idx_s] != 2'b00) begin
                bht_r[upd_idx_s] <= bht_r[upd_idx_s] - 2'b01;
            end
        end
    end
`else
    assign fetch_pred_taken = 1'b0;
    assign pred_s           = 1'b0;
    assign unused_s         = ^{fetch_pc, pred_r, BHT_IDX_W[0]};
`endif

endmodule
